duck_motion_ctl: RTL and testbench

Frame-rate motion controller for one duck sprite. It generates the `xpos`/`ypos` top-left coordinates and the facing direction consumed by the moving-sprite draw stage directly downstream. It runs the per-duck life cycle: spawn, fly with edge bounce, hit freeze, fall and optional escape. It signals game logic when the duck has landed or escaped.

---
 rtl/duck_motion_if.sv | 19 +
 rtl/duck_motion_ctl.sv | 176 +++++++++++++++++
 tb/tb_duck_motion_ctl.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/duck_motion_if.sv
// Game-logic <-> duck motion controller bundle: control pulses in, sprite
// coordinates and life-cycle status out.
interface duck_motion_if;
  logic        game_enable;
  logic        vsync;
  logic        spawn;
  logic        hit;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic        dir_left;
  logic [2:0]  duck_state;
  logic        fallen;
  logic        escaped;

  modport master (output game_enable, vsync, spawn, hit,
                  input  xpos, ypos, dir_left, duck_state, fallen, escaped);
  modport slave  (input  game_enable, vsync, spawn, hit,
                  output xpos, ypos, dir_left, duck_state, fallen, escaped);
endinterface

// File: rtl/duck_motion_ctl.sv
// Per-frame duck sprite motion: spawn, bounce flight, hit freeze, fall.
// Define DUCK_ESCAPE_EN to add the timed escape through the top edge.
module duck_motion_ctl #(
  parameter int H_RES         = 1024,
  parameter int SPRITE_W      = 128,
  parameter int SPRITE_H      = 96,
  parameter int Y_MIN         = 0,
  parameter int Y_MAX         = 576,
  parameter int SPEED_X       = 4,
  parameter int SPEED_Y       = 3,
  parameter int FALL_SPEED    = 6,
  parameter int HIT_FRAMES    = 30,
  parameter int ESCAPE_FRAMES = 600
) (
  input  logic          clk,
  input  logic          rst,
  duck_motion_if.slave  bus
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_FLY  = 3'd1;
  localparam logic [2:0] S_HIT  = 3'd2;
  localparam logic [2:0] S_FALL = 3'd3;
`ifdef DUCK_ESCAPE_EN
  localparam logic [2:0] S_ESC  = 3'd4;
`endif

  localparam logic [12:0] XMAX = 13'(H_RES - SPRITE_W);
  localparam logic [12:0] YMIN = 13'(Y_MIN);
  localparam logic [12:0] YMAX = 13'(Y_MAX);
  localparam logic [12:0] SX   = 13'(SPEED_X);
  localparam logic [12:0] SY   = 13'(SPEED_Y);
  localparam logic [12:0] FS   = 13'(FALL_SPEED);

  // Sprite must fit the 12-bit coordinate space and frame counts the counter.
  if (H_RES < SPRITE_W || Y_MAX + SPRITE_H > 4096 || HIT_FRAMES < 1 ||
      HIT_FRAMES > 65535 || ESCAPE_FRAMES < 1 || ESCAPE_FRAMES > 65535) begin : g_bad_cfg
    $error("duck_motion_ctl: parameter set out of range");
  end

  logic        vsync_d, tick;
  logic [11:0] lfsr;
  logic [2:0]  state;
  logic [11:0] xpos, ypos;
  logic        dir_left, up, fallen;
  logic [15:0] cnt;

  assign tick = bus.vsync & ~vsync_d;

  // One flight step, evaluated on 13 bits so edge tests never wrap.
  logic [12:0] x13, y13;
  logic [11:0] x_step, y_step;
  logic        dir_nx, up_nx;
  assign x13 = {1'b0, xpos};
  assign y13 = {1'b0, ypos};

  always_comb begin
    x_step = xpos;
    y_step = ypos;
    dir_nx = dir_left;
    up_nx  = up;
    if (!dir_left) begin
      if (x13 + SX > XMAX) begin x_step = XMAX[11:0]; dir_nx = 1'b1; end
      else                       x_step = xpos + SX[11:0];
    end else begin
      if (x13 < SX) begin x_step = 12'd0; dir_nx = 1'b0; end
      else                x_step = xpos - SX[11:0];
    end
    if (up) begin
      if (y13 < YMIN + SY) begin y_step = YMIN[11:0]; up_nx = 1'b0; end
      else                       y_step = ypos - SY[11:0];
    end else begin
      if (y13 + SY > YMAX) begin y_step = YMAX[11:0]; up_nx = 1'b1; end
      else                       y_step = ypos + SY[11:0];
    end
  end

`ifdef DUCK_ESCAPE_EN
  logic escaped;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_d  <= 1'b0;
      lfsr     <= 12'hACE;
      state    <= S_IDLE;
      xpos     <= 12'd0;
      ypos     <= YMAX[11:0];
      dir_left <= 1'b0;
      up       <= 1'b0;
      cnt      <= 16'd0;
      fallen   <= 1'b0;
`ifdef DUCK_ESCAPE_EN
      escaped  <= 1'b0;
`endif
    end else begin
      vsync_d <= bus.vsync;
      lfsr    <= {lfsr[10:0], lfsr[11] ^ lfsr[5] ^ lfsr[3] ^ lfsr[0]};
      fallen  <= 1'b0;
`ifdef DUCK_ESCAPE_EN
      escaped <= 1'b0;
`endif
      if (!bus.game_enable) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: if (bus.spawn) begin
            state    <= S_FLY;
            xpos     <= 12'd64 + {3'b000, lfsr[8:0]};
            ypos     <= YMAX[11:0];
            dir_left <= lfsr[11];
            up       <= 1'b1;
            cnt      <= 16'd0;
          end
          // A hit landing on a tick cycle freezes the pre-tick position.
          S_FLY: if (bus.hit) begin
            state <= S_HIT;
            cnt   <= 16'd0;
          end else if (tick) begin
            xpos     <= x_step;
            ypos     <= y_step;
            dir_left <= dir_nx;
            up       <= up_nx;
`ifdef DUCK_ESCAPE_EN
            if (cnt == 16'(ESCAPE_FRAMES - 1)) begin
              state <= S_ESC;
              cnt   <= 16'd0;
            end else begin
              cnt <= cnt + 16'd1;
            end
`endif
          end
          S_HIT: if (tick) begin
            if (cnt == 16'(HIT_FRAMES - 1)) begin
              state <= S_FALL;
              cnt   <= 16'd0;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          S_FALL: if (tick) begin
            if (y13 + FS >= YMAX) begin
              ypos   <= YMAX[11:0];
              fallen <= 1'b1;
              state  <= S_IDLE;
            end else begin
              ypos <= ypos + FS[11:0];
            end
          end
`ifdef DUCK_ESCAPE_EN
          S_ESC: if (tick) begin
            if (y13 < SY) begin
              ypos    <= 12'd0;
              escaped <= 1'b1;
              state   <= S_IDLE;
            end else begin
              ypos <= ypos - SY[11:0];
            end
          end
`endif
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.xpos       = xpos;
  assign bus.ypos       = ypos;
  assign bus.dir_left   = dir_left;
  assign bus.duck_state = state;
  assign bus.fallen     = fallen;
`ifdef DUCK_ESCAPE_EN
  assign bus.escaped    = escaped;
`else
  assign bus.escaped    = 1'b0;
`endif
endmodule

// File: tb/tb_duck_motion_ctl.sv
// Directed bench for duck_motion_ctl: vector table for the early flight,
// hand sequences for bounce, hit/fall, enable drop, escape and reset.
module tb_duck_motion_ctl;
  localparam int OP_IDLE = 0, OP_TICK = 1, OP_HIT = 2, OP_HITTICK = 3, OP_SPAWN = 4;

  typedef struct {
    int op;
    int x;
    int y;
    int dl;
    int st;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  duck_motion_if bus();

  duck_motion_ctl dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Reference LFSR: 12-bit Fibonacci, taps 12,6,4,1, seed ACE.
  logic [11:0] m_lfsr;
  always @(posedge clk)
    if (rst) m_lfsr <= 12'hACE;
    else     m_lfsr <= {m_lfsr[10:0], m_lfsr[11] ^ m_lfsr[5] ^ m_lfsr[3] ^ m_lfsr[0]};

  int n_fallen = 0, n_escaped = 0, n_badpulse = 0;
  always @(negedge clk) begin
    if (bus.fallen)  n_fallen  <= n_fallen + 1;
    if (bus.escaped) n_escaped <= n_escaped + 1;
    if ((bus.fallen || bus.escaped) && bus.duck_state != 3'd0) n_badpulse <= n_badpulse + 1;
  end

  int checks = 0, passes = 0;
  int mx, my, mdl, mup;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic do_tick();
    bus.vsync = 1'b1; cyc(2); bus.vsync = 1'b0; cyc(1);
  endtask

  task automatic do_hit_tick();
    bus.vsync = 1'b1; bus.hit = 1'b1; cyc(1);
    bus.hit = 1'b0; cyc(1);
    bus.vsync = 1'b0; cyc(1);
  endtask

  task automatic do_hit();
    bus.hit = 1'b1; cyc(1); bus.hit = 1'b0;
  endtask

  task automatic do_spawn();
    logic [11:0] v;
    v = m_lfsr;
    bus.spawn = 1'b1; cyc(1); bus.spawn = 1'b0;
    mx = 64 + int'(v[8:0]); my = 576; mdl = int'(v[11]); mup = 1;
  endtask

  // Flight step straight from the motion rules for default geometry.
  task automatic model_fly();
    if (mdl == 0) begin
      if (mx + 4 > 896) begin mx = 896; mdl = 1; end else mx = mx + 4;
    end else begin
      if (mx < 4) begin mx = 0; mdl = 0; end else mx = mx - 4;
    end
    if (mup == 1) begin
      if (my < 3) begin my = 0; mup = 0; end else my = my - 3;
    end else begin
      if (my + 3 > 576) begin my = 576; mup = 1; end else my = my + 3;
    end
  endtask

  task automatic fly_ticks(input int n);
    repeat (n) begin do_tick(); model_fly(); end
  endtask

  task automatic chk_pos(input string nm);
    chk({nm, "_x"}, int'(bus.xpos), mx);
    chk({nm, "_y"}, int'(bus.ypos), my);
    chk({nm, "_dir"}, int'(bus.dir_left), mdl);
  endtask

  task automatic wait_lfsr(input logic [11:0] mask, input logic [11:0] val);
    int found;
    found = 0;
    for (int i = 0; i < 5000 && found == 0; i++) begin
      if ((m_lfsr & mask) == val) found = 1;
      else cyc(1);
    end
    chk("lfsr_wait", found, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  vec_t tbl[8];
  int f0, e0, nt;

  initial begin
    tbl[0] = '{OP_TICK,    228, 573, 0, 1};
    tbl[1] = '{OP_TICK,    232, 570, 0, 1};
    tbl[2] = '{OP_IDLE,    232, 570, 0, 1};
    tbl[3] = '{OP_SPAWN,   232, 570, 0, 1};
    tbl[4] = '{OP_TICK,    236, 567, 0, 1};
    tbl[5] = '{OP_HITTICK, 236, 567, 0, 2};
    tbl[6] = '{OP_TICK,    236, 567, 0, 2};
    tbl[7] = '{OP_HIT,     236, 567, 0, 2};

    bus.game_enable = 1'b1; bus.vsync = 1'b0; bus.spawn = 1'b0; bus.hit = 1'b0;
    cyc(3);
    chk("rst_x", int'(bus.xpos), 0);
    chk("rst_y", int'(bus.ypos), 576);
    chk("rst_dir", int'(bus.dir_left), 0);
    chk("rst_state", int'(bus.duck_state), 0);
    chk("rst_fallen", int'(bus.fallen), 0);
    chk("rst_escaped", int'(bus.escaped), 0);
    rst = 1'b0;

    repeat (3) do_tick();
    chk("idle_x", int'(bus.xpos), 0);
    chk("idle_y", int'(bus.ypos), 576);
    chk("idle_state", int'(bus.duck_state), 0);
    chk("idle_pulses", n_fallen + n_escaped, 0);

    // Spawn with LFSR = 0A0 -> x = 64 + 160
    wait_lfsr(12'hFFF, 12'h0A0);
    do_spawn();
    chk("spawn_state", int'(bus.duck_state), 1);
    chk("spawn_x", int'(bus.xpos), 224);
    chk("spawn_y", int'(bus.ypos), 576);
    chk("spawn_dir", int'(bus.dir_left), 0);

    for (int i = 0; i < 8; i++) begin
      case (tbl[i].op)
        OP_TICK:    do_tick();
        OP_HIT:     do_hit();
        OP_HITTICK: do_hit_tick();
        OP_SPAWN:   begin bus.spawn = 1'b1; cyc(1); bus.spawn = 1'b0; end
        default:    cyc(1);
      endcase
      chk($sformatf("vec%0d_x", i), int'(bus.xpos), tbl[i].x);
      chk($sformatf("vec%0d_y", i), int'(bus.ypos), tbl[i].y);
      chk($sformatf("vec%0d_dir", i), int'(bus.dir_left), tbl[i].dl);
      chk($sformatf("vec%0d_state", i), int'(bus.duck_state), tbl[i].st);
    end

    // One hit tick already taken; 28 more stay in HIT, the 30th enters FALL.
    repeat (28) do_tick();
    chk("hit29_state", int'(bus.duck_state), 2);
    do_tick();
    chk("hit30_state", int'(bus.duck_state), 3);
    f0 = n_fallen;
    do_tick();
    chk("fall1_y", int'(bus.ypos), 573);
    chk("fall1_state", int'(bus.duck_state), 3);
    do_tick();
    chk("land_y", int'(bus.ypos), 576);
    chk("land_state", int'(bus.duck_state), 0);
    chk("land_fallen", n_fallen, f0 + 1);

    // Right-edge bounce from x = 894 moving right
    wait_lfsr(12'h803, 12'h002);
    do_spawn();
    nt = (894 - mx) / 4;
    fly_ticks(nt);
    chk("edge_pre_x", int'(bus.xpos), 894);
    chk("edge_pre_dir", int'(bus.dir_left), 0);
    chk("edge_pre_y", int'(bus.ypos), my);
    fly_ticks(1);
    chk("edge_x", int'(bus.xpos), 896);
    chk("edge_dir", int'(bus.dir_left), 1);
    fly_ticks(1);
    chk("edge_post_x", int'(bus.xpos), 892);
    chk("edge_post_dir", int'(bus.dir_left), 1);
    chk_pos("edge_post");

    // Hit, then drop game_enable as soon as FALL starts
    do_hit();
    chk("h2_state", int'(bus.duck_state), 2);
    repeat (30) do_tick();
    chk("h2_fall_state", int'(bus.duck_state), 3);
    chk_pos("h2_frozen");
    f0 = n_fallen;
    bus.game_enable = 1'b0; bus.spawn = 1'b1; cyc(1); bus.spawn = 1'b0;
    chk("dis_state", int'(bus.duck_state), 0);
    repeat (2) do_tick();
    chk("dis_state2", int'(bus.duck_state), 0);
    chk_pos("dis_hold");
    chk("dis_no_fallen", n_fallen, f0);
    bus.game_enable = 1'b1; cyc(1);

    // Hit on a tick cycle at y = 300, then full fall to the ground
    do_spawn();
    fly_ticks(92);
    chk("h3_pre_y", int'(bus.ypos), 300);
    do_hit_tick();
    chk("h3_state", int'(bus.duck_state), 2);
    chk("h3_y", int'(bus.ypos), 300);
    chk("h3_x", int'(bus.xpos), mx);
    repeat (29) do_tick();
    chk("h3_29_state", int'(bus.duck_state), 2);
    do_tick();
    chk("h3_fall_state", int'(bus.duck_state), 3);
    f0 = n_fallen;
    repeat (45) do_tick();
    chk("h3_fall45_y", int'(bus.ypos), 570);
    chk("h3_fall45_state", int'(bus.duck_state), 3);
    chk("h3_fall45_nopulse", n_fallen, f0);
    do_tick();
    chk("h3_land_y", int'(bus.ypos), 576);
    chk("h3_land_state", int'(bus.duck_state), 0);
    chk("h3_land_fallen", n_fallen, f0 + 1);

    do_spawn();
    e0 = n_escaped;
`ifdef DUCK_ESCAPE_EN
    nt = 0;
    for (int i = 0; i < 700 && bus.duck_state == 3'd1; i++) begin do_tick(); nt++; end
    chk("esc_enter_ticks", nt, 600);
    chk("esc_state", int'(bus.duck_state), 4);
    for (int i = 0; i < 400 && bus.duck_state == 3'd4; i++) do_tick();
    chk("esc_y", int'(bus.ypos), 0);
    chk("esc_state_idle", int'(bus.duck_state), 0);
    chk("esc_pulse", n_escaped, e0 + 1);
    do_spawn();
`else
    repeat (1000) do_tick();
    chk("noesc_state", int'(bus.duck_state), 1);
    chk("noesc_pulse", n_escaped, e0);
`endif

    // Reset mid-flight
    f0 = n_fallen; e0 = n_escaped;
    do_tick();
    rst = 1'b1; cyc(1);
    chk("mid_rst_x", int'(bus.xpos), 0);
    chk("mid_rst_y", int'(bus.ypos), 576);
    chk("mid_rst_dir", int'(bus.dir_left), 0);
    chk("mid_rst_state", int'(bus.duck_state), 0);
    rst = 1'b0; cyc(2);
    chk("mid_rst_pulses", n_fallen + n_escaped, f0 + e0);
    chk("pulse_with_idle", n_badpulse, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
